// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives ALUOp for the ALU control decoder.
// Memory accesses stall on mem_ready and abort after MEM_TIMEOUT stalled cycles (0 disables).
// Undecodable opcodes pulse illegal_op, and retired instructions are counted.
// Optional feature: define MC_ADDI_EN to decode addi (opcode 001000) through ADDIEX/ADDIWB.
// Without MC_ADDI_EN, addi is treated as illegal and states 10-11 are unreachable.

module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             mem_err,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Threshold and enable for the stalled-access abort; a zero timeout never fires.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_L  = TIMEOUT_W'(MEM_TIMEOUT);
    localparam logic                 TIMEOUT_EN = (MEM_TIMEOUT != 32'sd0);

    state_t               state_r;
    state_t               next_state_s;
    logic [TIMEOUT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]     instr_count_r;
    logic                 is_mem_s;
    logic                 timeout_s;
    logic                 illegal_s;

    // Classify memory states and detect an access that has stalled too long.
    always_comb begin
        is_mem_s  = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
        timeout_s = TIMEOUT_EN && is_mem_s && !mem_ready && (wait_cnt_r == TIMEOUT_L);
    end

    // Next-state selection; a timeout always returns to FETCH without retiring.
    always_comb begin
        next_state_s = state_r;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (timeout_s) begin
                    next_state_s = S_FETCH;
                end else if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_J:         next_state_s = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      next_state_s = S_ADDIEX;
`endif
                    default: begin
                        next_state_s = S_FETCH;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (timeout_s) begin
                    next_state_s = S_FETCH;
                end else if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (timeout_s || mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_MEMWB:  next_state_s = S_FETCH;
            S_EXEC:   next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: next_state_s = S_ADDIWB;
            S_ADDIWB: next_state_s = S_FETCH;
`endif
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the current state, plus the few input-qualified terms.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: begin
                mem_req = 1'b0;
            end
        endcase
        illegal_op = illegal_s;
        mem_err    = timeout_s;
        state_o    = state_r;
    end

    // State register, stall counter and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_FETCH;
            wait_cnt_r    <= '0;
            instr_count_r <= '0;
        end else begin
            state_r <= next_state_s;
            if ((next_state_s != state_r) || timeout_s) begin
                wait_cnt_r <= '0;
            end else if (is_mem_s && !mem_ready && (wait_cnt_r != '1)) begin
                wait_cnt_r <= wait_cnt_r + TIMEOUT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (instr_done) begin
                instr_count_r <= instr_count_r + CNT_W'(1);
            end else begin
                instr_count_r <= instr_count_r;
            end
        end
    end

    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl (MEM_TIMEOUT=4). Stimulus pushes the expected
// control vector for each cycle; a negedge monitor pops and compares against the DUT.

module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic        alu_src_a, instr_done, illegal_op, mem_err;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state_o;
    logic [31:0] instr_count;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .TIMEOUT_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_err(mem_err), .state_o(state_o),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] v;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;

    // Expected control vector {state, mem_req, mem_we, iord, ir_write, pc_write, reg_write,
    // reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, mem_err}
    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                            input logic mr, input logic z, input logic err);
        logic req, we, io, irw, pcw, rw, rd, m2r, asa, done, ill;
        logic [1:0] asb, aop, psrc;
        logic legal;
        {req, we, io, irw, pcw, rw, rd, m2r, asa, done, ill} = 11'd0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b000010);
`ifdef MC_ADDI_EN
        legal = legal || (op == 6'b001000);
`endif
        case (st)
            4'd0: begin req = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1: begin asb = 2'b11; ill = !legal; end
            4'd2: begin asa = 1'b1; asb = 2'b10; end
            4'd3: begin req = 1'b1; io = 1'b1; end
            4'd4: begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            4'd5: begin req = 1'b1; we = 1'b1; io = 1'b1; done = mr; end
            4'd6: begin asa = 1'b1; aop = 2'b10; end
            4'd7: begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            4'd8: begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcw = z; done = 1'b1; end
            4'd9: begin psrc = 2'b10; pcw = 1'b1; done = 1'b1; end
            4'd10: begin asa = 1'b1; asb = 2'b10; end
            4'd11: begin rw = 1'b1; done = 1'b1; end
            default: begin req = 1'b0; end
        endcase
        return {st, req, we, io, irw, pcw, rw, rd, m2r, asa, asb, aop, psrc, done, ill, err};
    endfunction

    task automatic push_exp(input string tag, input logic [21:0] v);
        exp_t e;
        e.v = v; e.cnt = exp_cnt; e.tag = tag;
        sb.push_back(e);
        if (v[2]) exp_cnt = exp_cnt + 32'd1;
    endtask

    // One clock of stimulus with the hand-chosen expected state for that cycle.
    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input logic z, input logic [3:0] st, input logic err);
        @(posedge clk); #1;
        rst_n = 1'b1; opcode = op; mem_ready = mr; zero = z;
        push_exp(tag, exp_vec(st, op, mr, z, err));
    endtask

    // One clock with reset asserted shortly after the edge; FETCH values expected at once.
    task automatic rst_step(input string tag, input logic mr);
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ready = mr;
        exp_cnt = 32'd0;
        push_exp(tag, exp_vec(4'd0, opcode, mr, zero, 1'b0));
    endtask

    // Monitor: compare the DUT against the oldest expectation on every falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_cmp = n_cmp + 1;
            if (({state_o, mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op,
                  mem_err} !== mon_e.v) || (instr_count !== mon_e.cnt)) begin
                n_err = n_err + 1;
                $display("FAIL %s: got vec=%h cnt=%0d, expected vec=%h cnt=%0d", mon_e.tag,
                         {state_o, mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                          instr_done, illegal_op, mem_err}, instr_count, mon_e.v, mon_e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with mem_ready high and low.
        rst_step("rst_mr1", 1'b1);
        rst_step("rst_mr0", 1'b0);
        // FETCH timeout: 5th stalled cycle aborts, then the counter restarts.
        for (int i = 0; i < 4; i++) step("fetch_stall", 6'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        step("fetch_timeout", 6'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        step("fetch_restart", 6'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        // R-type.
        step("r_fetch",  6'b000000, 1'b1, 1'b0, 4'd0, 1'b0);
        step("r_decode", 6'b000000, 1'b1, 1'b0, 4'd1, 1'b0);
        step("r_exec",   6'b000000, 1'b1, 1'b0, 4'd6, 1'b0);
        step("r_aluwb",  6'b000000, 1'b1, 1'b0, 4'd7, 1'b0);
        // lw with three stalls in MEMRD.
        step("lw_fetch",  6'b100011, 1'b1, 1'b0, 4'd0, 1'b0);
        step("lw_decode", 6'b100011, 1'b1, 1'b0, 4'd1, 1'b0);
        step("lw_memadr", 6'b100011, 1'b0, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) step("lw_memrd_stall", 6'b100011, 1'b0, 1'b0, 4'd3, 1'b0);
        step("lw_memrd_done", 6'b100011, 1'b1, 1'b0, 4'd3, 1'b0);
        step("lw_memwb",      6'b100011, 1'b1, 1'b0, 4'd4, 1'b0);
        // beq taken and not taken.
        step("beq1_fetch",  6'b000100, 1'b1, 1'b1, 4'd0, 1'b0);
        step("beq1_decode", 6'b000100, 1'b1, 1'b1, 4'd1, 1'b0);
        step("beq1_branch", 6'b000100, 1'b1, 1'b1, 4'd8, 1'b0);
        step("beq0_fetch",  6'b000100, 1'b1, 1'b0, 4'd0, 1'b0);
        step("beq0_decode", 6'b000100, 1'b1, 1'b0, 4'd1, 1'b0);
        step("beq0_branch", 6'b000100, 1'b1, 1'b0, 4'd8, 1'b0);
        // Illegal opcode.
        step("ill_fetch",  6'b111111, 1'b1, 1'b0, 4'd0, 1'b0);
        step("ill_decode", 6'b111111, 1'b1, 1'b0, 4'd1, 1'b0);
        // addi: decoded only with the optional feature.
        step("addi_fetch",  6'b001000, 1'b1, 1'b0, 4'd0, 1'b0);
        step("addi_decode", 6'b001000, 1'b1, 1'b0, 4'd1, 1'b0);
`ifdef MC_ADDI_EN
        step("addi_ex", 6'b001000, 1'b1, 1'b0, 4'd10, 1'b0);
        step("addi_wb", 6'b001000, 1'b1, 1'b0, 4'd11, 1'b0);
`endif
        // Jump.
        step("j_fetch",  6'b000010, 1'b1, 1'b0, 4'd0, 1'b0);
        step("j_decode", 6'b000010, 1'b1, 1'b0, 4'd1, 1'b0);
        step("j_jump",   6'b000010, 1'b1, 1'b0, 4'd9, 1'b0);
        // sw with one stall.
        step("sw_fetch",  6'b101011, 1'b1, 1'b0, 4'd0, 1'b0);
        step("sw_decode", 6'b101011, 1'b1, 1'b0, 4'd1, 1'b0);
        step("sw_memadr", 6'b101011, 1'b1, 1'b0, 4'd2, 1'b0);
        step("sw_stall",  6'b101011, 1'b0, 1'b0, 4'd5, 1'b0);
        step("sw_done",   6'b101011, 1'b1, 1'b0, 4'd5, 1'b0);
        // MEMRD timeout: four stalls then abort.
        step("lwto_fetch",  6'b100011, 1'b1, 1'b0, 4'd0, 1'b0);
        step("lwto_decode", 6'b100011, 1'b1, 1'b0, 4'd1, 1'b0);
        step("lwto_memadr", 6'b100011, 1'b0, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) step("lwto_stall", 6'b100011, 1'b0, 1'b0, 4'd3, 1'b0);
        step("lwto_abort", 6'b100011, 1'b0, 1'b0, 4'd3, 1'b1);
        // Ready arriving exactly at the timeout threshold completes normally.
        step("lwb_fetch",  6'b100011, 1'b1, 1'b0, 4'd0, 1'b0);
        step("lwb_decode", 6'b100011, 1'b1, 1'b0, 4'd1, 1'b0);
        step("lwb_memadr", 6'b100011, 1'b0, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) step("lwb_stall", 6'b100011, 1'b0, 1'b0, 4'd3, 1'b0);
        step("lwb_ready_at_limit", 6'b100011, 1'b1, 1'b0, 4'd3, 1'b0);
        step("lwb_memwb",          6'b100011, 1'b1, 1'b0, 4'd4, 1'b0);
        // Reset asserted while in MEMWR.
        step("swr_fetch",  6'b101011, 1'b1, 1'b0, 4'd0, 1'b0);
        step("swr_decode", 6'b101011, 1'b1, 1'b0, 4'd1, 1'b0);
        step("swr_memadr", 6'b101011, 1'b1, 1'b0, 4'd2, 1'b0);
        step("swr_stall",  6'b101011, 1'b0, 1'b0, 4'd5, 1'b0);
        rst_step("swr_reset", 1'b0);
        // Back to normal after reset.
        step("post_fetch",  6'b000000, 1'b1, 1'b0, 4'd0, 1'b0);
        step("post_decode", 6'b000000, 1'b1, 1'b0, 4'd1, 1'b0);
        step("post_exec",   6'b000000, 1'b1, 1'b0, 4'd6, 1'b0);
        step("post_aluwb",  6'b000000, 1'b1, 1'b0, 4'd7, 1'b0);
        step("post_fetch2", 6'b000000, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
